// File: rtl/pacoblaze_interrupt_controller.sv
// Fixed-priority interrupt controller for the pacoblaze3 interrupt/interrupt_ack pair.
// Latches source events, raises one request at a time and exposes its registers on the core I/O bus.
module pacoblaze_interrupt_controller #(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [7:0]  MASK_PORT = 8'h08,
  parameter logic [7:0]  VEC_PORT  = 8'h09,
  parameter logic [7:0]  EOI_PORT  = 8'h0A,
  parameter logic [7:0]  STAT_PORT = 8'h0B
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src_event,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic [7:0]         out_port,
  output logic [7:0]         in_port,
  output logic               interrupt,
  input  logic               interrupt_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_SRC-1:0] mask_reg;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] overrun_reg, overrun_next;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_clear;
  logic [7:0]         vector_reg, vector_next;
  logic               interrupt_next;
  logic [2:0]         grant_id;
  logic               grant_valid;
  logic               ack_take;
  logic               mask_wr;
  logic               eoi_wr;
  logic               stat_rd;
  logic [7:0]         mask_ext;
  logic [7:0]         stat_word;
  logic [7:0]         read_mux;
  logic               unused_bits;

  assign mask_wr  = write_strobe && (port_id == MASK_PORT);
  assign eoi_wr   = write_strobe && (port_id == EOI_PORT);
  assign stat_rd  = read_strobe  && (port_id == STAT_PORT);
  assign eligible = pending_reg & mask_reg;

  // Bits above NUM_SRC of the write data have no register behind them.
  assign unused_bits = ^out_port;

  // Lowest index wins: scan downward so the last hit is the smallest set bit.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_valid = 1'b1;
        grant_id    = 3'(i);
      end
    end
  end

  assign ack_take = (state_reg == REQ) && interrupt_ack && grant_valid;

  // Per-source latches: a new event always wins over the ack clear or the status-read clear.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign ack_clear[gi]    = ack_take && (grant_id == 3'(gi));
      assign pending_next[gi] = src_event[gi] | (pending_reg[gi] & ~ack_clear[gi]);
      assign overrun_next[gi] = (src_event[gi] & pending_reg[gi]) | (overrun_reg[gi] & ~stat_rd);
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    interrupt_next = 1'b0;
    vector_next    = vector_reg;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          state_next     = REQ;
          interrupt_next = 1'b1;
        end
      end
      REQ: begin
        if (interrupt_ack) begin
          state_next  = SERVICE;
          vector_next = grant_valid ? {1'b1, 4'b0000, grant_id} : 8'hFF;
        end else if (!(|eligible)) begin
          state_next = IDLE;
        end else begin
          interrupt_next = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi_wr) begin
          state_next  = IDLE;
          vector_next = {1'b0, vector_reg[6:0]};
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mask_ext  = 8'(mask_reg);
  assign stat_word = 8'((16'(overrun_reg) << NUM_SRC) | 16'(pending_reg));

  always_comb begin
    read_mux = 8'h00;
    case (port_id)
      MASK_PORT: read_mux = mask_ext;
      VEC_PORT:  read_mux = vector_reg;
      STAT_PORT: read_mux = stat_word;
      default:   read_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      interrupt   <= 1'b0;
      in_port     <= 8'h00;
      mask_reg    <= '0;
      pending_reg <= '0;
      overrun_reg <= '0;
      vector_reg  <= 8'h00;
    end else begin
      state_reg   <= state_next;
      interrupt   <= interrupt_next;
      in_port     <= read_mux;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      vector_reg  <= vector_next;
      if (mask_wr) begin
        mask_reg <= out_port[NUM_SRC-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pacoblaze_interrupt_controller.sv
// Directed and randomized checks of the interrupt controller against a cycle-level behavioural model.
module tb_pacoblaze_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] src_event = 4'h0;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  // Behavioural model: registers as bytes, "requesting" and "in service" as plain flags.
  bit [7:0] m_mask, m_pend, m_ovr, m_vec, m_in;
  bit       m_irq, m_svc;

  pacoblaze_interrupt_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_event    (src_event),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict from pre-edge state and inputs, advance, then compare after the edge.
  task automatic tick();
    bit [7:0] elig, low, src8, n_mask, n_pend, n_ovr, n_vec, n_in;
    bit       n_irq, n_svc;
    int       idx;
    src8 = {4'h0, src_event};
    elig = m_pend & m_mask;
    low  = elig & (~elig + 8'd1);
    idx  = 0;
    for (int i = 0; i < 8; i++) if (low[i]) idx = i;
    n_mask = m_mask; n_pend = m_pend; n_ovr = m_ovr; n_vec = m_vec;
    n_irq  = m_irq;  n_svc  = m_svc;
    if (port_id == 8'h08)      n_in = m_mask;
    else if (port_id == 8'h09) n_in = m_vec;
    else if (port_id == 8'h0B) n_in = {m_ovr[3:0], m_pend[3:0]};
    else                       n_in = 8'h00;
    if (!reset_n) begin
      n_mask = 0; n_pend = 0; n_ovr = 0; n_vec = 0; n_in = 0; n_irq = 0; n_svc = 0;
    end else begin
      if (m_irq) begin
        if (interrupt_ack) begin
          n_irq = 0; n_svc = 1;
          if (elig != 0) begin
            n_pend = n_pend & ~low;
            n_vec  = 8'h80 + 8'(idx);
          end else begin
            n_vec = 8'hFF;
          end
        end else if (elig == 0) begin
          n_irq = 0;
        end
      end else if (m_svc) begin
        if (write_strobe && port_id == 8'h0A) begin
          n_svc = 0;
          n_vec = m_vec & 8'h7F;
        end
      end else if (elig != 0) begin
        n_irq = 1;
      end
      n_pend = n_pend | src8;
      if (read_strobe && port_id == 8'h0B) n_ovr = 0;
      n_ovr = n_ovr | (src8 & m_pend);
      if (write_strobe && port_id == 8'h08) n_mask = out_port & 8'h0F;
    end
    @(posedge clk);
    m_mask = n_mask; m_pend = n_pend; m_ovr = n_ovr; m_vec = n_vec;
    m_in = n_in; m_irq = n_irq; m_svc = n_svc;
    #1;
    if (!reset_n || write_strobe || read_strobe || interrupt_ack || src_event != 0)
      $display("txn t=%0t rst_n=%b src=%h port=%h wr=%b rd=%b data=%h ack=%b -> irq=%b in_port=%h",
               $time, reset_n, src_event, port_id, write_strobe, read_strobe, out_port,
               interrupt_ack, interrupt, in_port);
    check8("model_irq", {7'd0, interrupt}, {7'd0, m_irq});
    check8("model_in_port", in_port, m_in);
  endtask

  task automatic wr(input bit [7:0] p, input bit [7:0] d);
    port_id = p; out_port = d; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
  endtask

  task automatic rd(input bit [7:0] p, output logic [7:0] v);
    port_id = p; read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0; port_id = 8'h00;
    v = in_port;
  endtask

  task automatic pulse(input bit [3:0] s);
    src_event = s;
    tick();
    src_event = 4'h0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    bit [7:0] ports [5];

    // Reset state
    reset_n = 1'b0;
    tick(); tick();
    check8("reset_irq", {7'd0, interrupt}, 8'h00);
    check8("reset_in_port", in_port, 8'h00);
    reset_n = 1'b1;

    // Single source: latency, ack, vector, EOI
    wr(8'h08, 8'h03);
    pulse(4'b0010);
    check8("lat_edge_n", {7'd0, interrupt}, 8'h00);
    tick();
    check8("lat_edge_n1", {7'd0, interrupt}, 8'h01);
    ack();
    check8("ack_drops_irq", {7'd0, interrupt}, 8'h00);
    rd(8'h09, v); check8("vec_src1", v, 8'h81);
    rd(8'h0B, v); check8("stat_cleared", v, 8'h00);
    wr(8'h0A, 8'h5A);
    rd(8'h09, v); check8("vec_after_eoi", v, 8'h01);

    // Two simultaneous sources: lowest index first, next one after EOI
    pulse(4'b0011);
    tick();
    check8("dual_irq", {7'd0, interrupt}, 8'h01);
    ack();
    rd(8'h09, v); check8("dual_first_vec", v, 8'h80);
    rd(8'h09, v); check8("no_nesting", {7'd0, interrupt}, 8'h00);
    wr(8'h0A, 8'h00);
    tick();
    check8("dual_second_irq", {7'd0, interrupt}, 8'h01);
    ack();
    rd(8'h09, v); check8("dual_second_vec", v, 8'h81);
    wr(8'h0A, 8'h00);

    // Masked source pends silently, unmasking raises the request
    wr(8'h08, 8'h00);
    pulse(4'b0100);
    tick();
    check8("masked_no_irq", {7'd0, interrupt}, 8'h00);
    rd(8'h0B, v); check8("masked_stat", v, 8'h04);
    wr(8'h08, 8'h04);
    check8("unmask_same_edge", {7'd0, interrupt}, 8'h00);
    tick();
    check8("unmask_rise", {7'd0, interrupt}, 8'h01);

    // Mask cleared during REQ: withdraw, then spurious ack
    wr(8'h08, 8'h00);
    check8("withdraw_hold", {7'd0, interrupt}, 8'h01);
    tick();
    check8("withdraw_fall", {7'd0, interrupt}, 8'h00);
    wr(8'h08, 8'h04);
    tick();
    check8("rereq_irq", {7'd0, interrupt}, 8'h01);
    wr(8'h08, 8'h00);
    ack();
    rd(8'h09, v); check8("spurious_vec", v, 8'hFF);
    wr(8'h0A, 8'h00);
    rd(8'h09, v); check8("spurious_eoi_vec", v, 8'h7F);

    // Overrun: two events without service, status read clears overrun
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    pulse(4'b1000);
    pulse(4'b1000);
    rd(8'h0B, v); check8("overrun_stat", v, 8'h88);
    rd(8'h0B, v); check8("overrun_cleared", v, 8'h08);

    // Reset during SERVICE, no EOI needed afterwards
    wr(8'h08, 8'h08);
    tick();
    ack();
    rd(8'h09, v); check8("svc_vec", v, 8'h83);
    reset_n = 1'b0;
    port_id = 8'h09;
    tick();
    reset_n = 1'b1;
    check8("svc_reset_irq", {7'd0, interrupt}, 8'h00);
    check8("svc_reset_in_port", in_port, 8'h00);
    rd(8'h08, v); check8("svc_reset_mask", v, 8'h00);
    rd(8'h09, v); check8("svc_reset_vec", v, 8'h00);
    rd(8'h0B, v); check8("svc_reset_stat", v, 8'h00);
    wr(8'h08, 8'h01);
    pulse(4'b0001);
    tick();
    check8("post_reset_irq", {7'd0, interrupt}, 8'h01);

    // Randomized traffic against the model
    ports[0] = 8'h08; ports[1] = 8'h09; ports[2] = 8'h0A; ports[3] = 8'h0B; ports[4] = 8'h00;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      ports[4]      = 8'($urandom);
      src_event     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      port_id       = ports[$urandom_range(0, 4)];
      write_strobe  = (r < 2);
      read_strobe   = (r == 2 || r == 3);
      out_port      = 8'($urandom);
      interrupt_ack = ($urandom_range(0, 3) == 0);
      reset_n       = ($urandom_range(0, 79) != 0);
      tick();
    end
    src_event = 4'h0; write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; reset_n = 1'b1; port_id = 8'h00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
